// File: rtl/lisp_mem_resp.sv
// Memory-side responder: accepts level-held read/write requests, services them
// against an internal word-addressed RAM after a fixed latency, returns busy/done.
module lisp_mem_resp #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rden_in,
    input  logic                 wren_in,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic                 mem_ret_out,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 err_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
    localparam logic [ADDR_W:0] DEPTH_Q  = (ADDR_W + 1)'(DEPTH);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 rd_op_q, rd_op_d;
    logic                 mem_ret_q, mem_ret_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] rdata_q;

    logic                 req_s;
    logic                 in_range_s;
    logic [IDX_W-1:0]     idx_s;
    logic                 ram_we_s;
    logic                 ram_re_s;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    assign req_s      = rden_in | wren_in;
    assign in_range_s = ({1'b0, addr_q} < DEPTH_Q);
    assign idx_s      = addr_q[IDX_W-1:0];

    // Next-state logic: request capture, latency countdown, abort and response hold.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_op_d  = rd_op_q;
        err_d    = 1'b0;
        ram_we_s = 1'b0;
        ram_re_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_INIT;
                    addr_d  = addr_in;
                    data_d  = data_in;
                    rd_op_d = rden_in;
                    err_d   = rden_in & wren_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    // Out-of-range writes are dropped; reads of them return zero.
                    state_d  = ST_RESP;
                    ram_we_s = ~rd_op_q & in_range_s;
                    ram_re_s = rd_op_q;
                    err_d    = ~in_range_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_ret_d = (state_d != ST_RESP);
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_op_q   <= 1'b0;
            mem_ret_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_op_q   <= rd_op_d;
            mem_ret_q <= mem_ret_d;
            err_q     <= err_d;
        end
    end

    // RAM array write port; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[idx_s] <= data_q;
        end
    end

    // Registered read port, loaded only on read-response entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (ram_re_s) begin
            rdata_q <= in_range_s ? mem_q[idx_s] : '0;
        end
    end

    assign mem_ret_out = mem_ret_q;
    assign data_out    = rdata_q;
    assign err_out     = err_q;

endmodule

// File: tb/tb_lisp_mem_resp.sv
// Directed self-checking bench for lisp_mem_resp with LATENCY=2, DEPTH=1024.
module tb_lisp_mem_resp;

    logic        clk;
    logic        rst;
    logic        rden_in;
    logic        wren_in;
    logic [15:0] addr_in;
    logic [31:0] data_in;
    logic        mem_ret_out;
    logic [31:0] data_out;
    logic        err_out;

    int n_checks;
    int n_pass;

    lisp_mem_resp #(
        .WORD_SIZE(32),
        .ADDR_W   (16),
        .DEPTH    (1024),
        .LATENCY  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rden_in    (rden_in),
        .wren_in    (wren_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .mem_ret_out(mem_ret_out),
        .data_out   (data_out),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request with bounded wait for done, then release.
    task automatic do_op(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
        rden_in = rd;
        wren_in = wr;
        addr_in = a;
        data_in = d;
        for (int i = 0; i < 20 && mem_ret_out !== 1'b0; i++) tick();
        check_eq("op_done", {31'd0, mem_ret_out}, 32'd0);
        rden_in = 1'b0;
        wren_in = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        rden_in  = 1'b0;
        wren_in  = 1'b0;
        addr_in  = 16'd0;
        data_in  = 32'd0;
        tick();
        tick();
        check_eq("rst_busy", {31'd0, mem_ret_out}, 32'd1);
        check_eq("rst_data", data_out, 32'd0);
        check_eq("rst_err", {31'd0, err_out}, 32'd0);
        rst = 1'b0;
        tick();

        // Write DEADBEEF to address 5, edge by edge.
        wren_in = 1'b1; addr_in = 16'd5; data_in = 32'hDEADBEEF;
        tick();
        check_eq("wr_e0_busy", {31'd0, mem_ret_out}, 32'd1);
        tick();
        check_eq("wr_e1_busy", {31'd0, mem_ret_out}, 32'd1);
        tick();
        check_eq("wr_e2_done", {31'd0, mem_ret_out}, 32'd0);
        check_eq("wr_data_hold", data_out, 32'd0);
        tick();
        check_eq("wr_hold_done", {31'd0, mem_ret_out}, 32'd0);
        wren_in = 1'b0;
        tick();
        check_eq("wr_drop_busy", {31'd0, mem_ret_out}, 32'd1);

        // Read address 5.
        rden_in = 1'b1;
        tick();
        tick();
        check_eq("rd_e1_busy", {31'd0, mem_ret_out}, 32'd1);
        check_eq("rd_e1_data", data_out, 32'd0);
        tick();
        check_eq("rd_e2_data", data_out, 32'hDEADBEEF);
        check_eq("rd_e2_done", {31'd0, mem_ret_out}, 32'd0);
        rden_in = 1'b0;
        tick();
        check_eq("rd_idle_busy", {31'd0, mem_ret_out}, 32'd1);
        check_eq("rd_idle_data", data_out, 32'hDEADBEEF);

        // Simultaneous read and write request.
        rden_in = 1'b1; wren_in = 1'b1; data_in = 32'h1;
        tick();
        check_eq("both_err_e0", {31'd0, err_out}, 32'd1);
        tick();
        check_eq("both_err_e1", {31'd0, err_out}, 32'd0);
        tick();
        check_eq("both_done", {31'd0, mem_ret_out}, 32'd0);
        check_eq("both_data", data_out, 32'hDEADBEEF);
        rden_in = 1'b0; wren_in = 1'b0;
        tick();
        do_op(1'b0, 1'b1, 16'd0, 32'h0000_0055);
        do_op(1'b1, 1'b0, 16'd0, 32'd0);
        check_eq("rd_addr0", data_out, 32'h0000_0055);
        do_op(1'b1, 1'b0, 16'd5, 32'd0);
        check_eq("both_kept", data_out, 32'hDEADBEEF);

        // Out-of-range write to DEPTH.
        wren_in = 1'b1; addr_in = 16'd1024; data_in = 32'h12345678;
        tick();
        check_eq("oor_wr_e0_err", {31'd0, err_out}, 32'd0);
        tick();
        tick();
        check_eq("oor_wr_err", {31'd0, err_out}, 32'd1);
        check_eq("oor_wr_done", {31'd0, mem_ret_out}, 32'd0);
        tick();
        check_eq("oor_wr_err_end", {31'd0, err_out}, 32'd0);
        wren_in = 1'b0;
        tick();

        // Out-of-range read returns zero with an error pulse.
        rden_in = 1'b1;
        tick();
        tick();
        tick();
        check_eq("oor_rd_data", data_out, 32'd0);
        check_eq("oor_rd_err", {31'd0, err_out}, 32'd1);
        check_eq("oor_rd_done", {31'd0, mem_ret_out}, 32'd0);
        rden_in = 1'b0;
        tick();
        do_op(1'b1, 1'b0, 16'd0, 32'd0);
        check_eq("oor_no_alias", data_out, 32'h0000_0055);

        // Aborted write to address 7.
        do_op(1'b0, 1'b1, 16'd7, 32'd0);
        wren_in = 1'b1; addr_in = 16'd7; data_in = 32'h0000AAAA;
        tick();
        wren_in = 1'b0;
        tick();
        check_eq("abort_busy1", {31'd0, mem_ret_out}, 32'd1);
        tick();
        tick();
        check_eq("abort_busy2", {31'd0, mem_ret_out}, 32'd1);
        do_op(1'b1, 1'b0, 16'd7, 32'd0);
        check_eq("abort_kept", data_out, 32'd0);

        // Reset during ACCESS of a write to address 9.
        do_op(1'b0, 1'b1, 16'd9, 32'h0000_0099);
        do_op(1'b1, 1'b0, 16'd9, 32'd0);
        check_eq("pre_rst_rd9", data_out, 32'h0000_0099);
        wren_in = 1'b1; addr_in = 16'd9; data_in = 32'h00000BAD;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", {31'd0, mem_ret_out}, 32'd1);
        check_eq("mid_rst_data", data_out, 32'd0);
        check_eq("mid_rst_err", {31'd0, err_out}, 32'd0);
        tick();
        wren_in = 1'b0;
        rst = 1'b0;
        tick();
        do_op(1'b1, 1'b0, 16'd9, 32'd0);
        check_eq("rst_kept9", data_out, 32'h0000_0099);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
